// File: rtl/sampler_pkg.sv
// Shared constants, sample record and width/reciprocal helpers for the
// raster-scan pixel sampler.
package sampler_pkg;

    localparam logic [15:0] PRNG_SEED_X = 16'h1ACE;
    localparam logic [15:0] PRNG_SEED_Y = 16'hC0DE;

    // Fields are sized for the largest supported frame; users slice to width.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  idx;
        logic        last_sample;
        logic        last_frame;
    } sample_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // round(2^frac / res)
    function automatic int recip(input int res, input int frac);
        return ((1 << frac) + res / 2) / res;
    endfunction

endpackage

// File: rtl/pixel_jitter_prng.sv
// 16-bit xorshift generator; rand_num is the next state, taken when enabled.
module pixel_jitter_prng #(
    parameter logic [15:0] SEED = 16'h1ACE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] rand_num
);

    logic [15:0] state_q;
    logic [15:0] t1, t2;

    always_comb begin
        t1       = state_q ^ (state_q << 7);
        t2       = t1 ^ (t1 >> 9);
        rand_num = t2 ^ (t2 << 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (enable) begin
            state_q <= rand_num;
        end
    end

endmodule

// File: rtl/pixel_sample_gen.sv
// Raster-scan sub-pixel sample generator: two-stage pipeline (counters and
// fixed-point positions, then normalised coordinates) behind a valid/ready port.
module pixel_sample_gen
    import sampler_pkg::*;
#(
    parameter int H_RES     = 800,
    parameter int V_RES     = 600,
    parameter int SPP       = 4,
    parameter int FRAC      = 16,
    parameter int JITTER_EN = 1,
    localparam int XW = clog2_min1(H_RES),
    localparam int YW = clog2_min1(V_RES),
    localparam int SW = clog2_min1(SPP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic [SW-1:0] sample_idx,
    output logic          last_sample,
    output logic          last_frame,
    output logic [FRAC:0] norm_x,
    output logic [FRAC:0] norm_y
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [XW-1:0]   X_MAX   = XW'(H_RES - 1);
    localparam logic [YW-1:0]   Y_MAX   = YW'(V_RES - 1);
    localparam logic [SW-1:0]   I_MAX   = SW'(SPP - 1);
    localparam logic [FRAC-1:0] RECIP_X = FRAC'(recip(H_RES, FRAC));
    localparam logic [FRAC-1:0] RECIP_Y = FRAC'(recip(V_RES, FRAC));
    localparam logic [FRAC-1:0] CENTRE  = {1'b1, {(FRAC-1){1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [XW-1:0]       cnt_x_q, cnt_x_d;
    logic [YW-1:0]       cnt_y_q, cnt_y_d;
    logic [SW-1:0]       cnt_i_q, cnt_i_d;
    logic                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    sample_t             s1_q, s1_d, s2_q;
    logic [XW+FRAC-1:0]  s1_posx_q, s1_posx_d;
    logic [YW+FRAC-1:0]  s1_posy_q, s1_posy_d;
    logic [FRAC:0]       norm_x_q, norm_x_d, norm_y_q, norm_y_d;
    logic [XW+2*FRAC-1:0] prod_x;
    logic [YW+2*FRAC-1:0] prod_y;
    logic [15:0]         rand_x, rand_y;
    logic [FRAC-1:0]     off_x, off_y;
    logic                stall, issue, last_i, last_x, last_y;
    logic                unused_bits;

    assign stall  = s2_valid_q & ~out_ready;
    assign issue  = (state_q == RUN) & ~stall;
    assign last_i = (cnt_i_q == I_MAX);
    assign last_x = (cnt_x_q == X_MAX);
    assign last_y = (cnt_y_q == Y_MAX);

    pixel_jitter_prng #(.SEED(PRNG_SEED_X)) u_prng_x (
        .clk(clk), .rst_n(rst_n), .enable(issue), .rand_num(rand_x)
    );
    pixel_jitter_prng #(.SEED(PRNG_SEED_Y)) u_prng_y (
        .clk(clk), .rst_n(rst_n), .enable(issue), .rand_num(rand_y)
    );

    assign off_x = (JITTER_EN != 0) ? rand_x[15 -: FRAC] : CENTRE;
    assign off_y = (JITTER_EN != 0) ? rand_y[15 -: FRAC] : CENTRE;

    // Full-width product; anything at or above 2^FRAC after the shift saturates.
    always_comb begin
        prod_x   = {{FRAC{1'b0}}, s1_posx_q} * {{(XW+FRAC){1'b0}}, RECIP_X};
        prod_y   = {{FRAC{1'b0}}, s1_posy_q} * {{(YW+FRAC){1'b0}}, RECIP_Y};
        norm_x_d = (|prod_x[XW+2*FRAC-1:2*FRAC]) ? {1'b0, {FRAC{1'b1}}}
                                                 : {1'b0, prod_x[2*FRAC-1:FRAC]};
        norm_y_d = (|prod_y[YW+2*FRAC-1:2*FRAC]) ? {1'b0, {FRAC{1'b1}}}
                                                 : {1'b0, prod_y[2*FRAC-1:FRAC]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        cnt_i_d    = cnt_i_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_d       = s1_q;
        s1_posx_d  = s1_posx_q;
        s1_posy_d  = s1_posy_q;

        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = issue;
        end

        if (issue) begin
            s1_d.x           = 16'(cnt_x_q);
            s1_d.y           = 16'(cnt_y_q);
            s1_d.idx         = 8'(cnt_i_q);
            s1_d.last_sample = last_i;
            s1_d.last_frame  = last_i & last_x & last_y;
            s1_posx_d        = {cnt_x_q, off_x};
            s1_posy_d        = {cnt_y_q, off_y};
            if (last_i) begin
                cnt_i_d = '0;
                if (last_x) begin
                    cnt_x_d = '0;
                    cnt_y_d = last_y ? '0 : cnt_y_q + 1'b1;
                end else begin
                    cnt_x_d = cnt_x_q + 1'b1;
                end
            end else begin
                cnt_i_d = cnt_i_q + 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue & last_i & last_x & last_y) state_d = DRAIN;
            DRAIN:   if (s2_valid_q & out_ready & s2_q.last_frame) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cnt_x_d    = '0;
            cnt_y_d    = '0;
            cnt_i_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            cnt_i_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s1_posx_q  <= '0;
            s1_posy_q  <= '0;
            norm_x_q   <= '0;
            norm_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            cnt_i_q    <= cnt_i_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s1_posx_q  <= s1_posx_d;
            s1_posy_q  <= s1_posy_d;
            if (!stall) begin
                s2_q     <= s1_q;
                norm_x_q <= norm_x_d;
                norm_y_q <= norm_y_d;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign out_valid   = s2_valid_q;
    assign pixel_x     = s2_q.x[XW-1:0];
    assign pixel_y     = s2_q.y[YW-1:0];
    assign sample_idx  = s2_q.idx[SW-1:0];
    assign last_sample = s2_q.last_sample;
    assign last_frame  = s2_q.last_frame;
    assign norm_x      = norm_x_q;
    assign norm_y      = norm_y_q;
    assign unused_bits = ^{rand_x, rand_y, s2_q};

endmodule

// File: tb/tb_pixel_sample_gen.sv
// Directed bench: 4x2x2 centre and jitter sampler instances plus an 800-wide
// instance for the right-edge saturation case.
module tb_pixel_sample_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] mx = 16'h1ACE;
    logic [15:0] my = 16'hC0DE;

    logic a_start = 0, a_abort = 0, a_ready = 0, a_busy, a_valid, a_ls, a_lf;
    logic [1:0] a_x;
    logic a_y, a_idx;
    logic [16:0] a_nx, a_ny;

    logic c_start = 0, c_abort = 0, c_ready = 0, c_busy, c_valid, c_ls, c_lf;
    logic [1:0] c_x;
    logic c_y, c_idx;
    logic [16:0] c_nx, c_ny;

    logic b_start = 0, b_abort = 0, b_ready = 0, b_busy, b_valid, b_ls, b_lf;
    logic [9:0] b_x;
    logic b_y, b_idx;
    logic [16:0] b_nx, b_ny;

    pixel_sample_gen #(.H_RES(4), .V_RES(2), .SPP(2), .FRAC(16), .JITTER_EN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .busy(a_busy),
        .out_valid(a_valid), .out_ready(a_ready), .pixel_x(a_x), .pixel_y(a_y),
        .sample_idx(a_idx), .last_sample(a_ls), .last_frame(a_lf), .norm_x(a_nx), .norm_y(a_ny)
    );
    pixel_sample_gen #(.H_RES(4), .V_RES(2), .SPP(2), .FRAC(16), .JITTER_EN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .busy(c_busy),
        .out_valid(c_valid), .out_ready(c_ready), .pixel_x(c_x), .pixel_y(c_y),
        .sample_idx(c_idx), .last_sample(c_ls), .last_frame(c_lf), .norm_x(c_nx), .norm_y(c_ny)
    );
    pixel_sample_gen #(.H_RES(800), .V_RES(2), .SPP(1), .FRAC(16), .JITTER_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .busy(b_busy),
        .out_valid(b_valid), .out_ready(b_ready), .pixel_x(b_x), .pixel_y(b_y),
        .sample_idx(b_idx), .last_sample(b_ls), .last_frame(b_lf), .norm_x(b_nx), .norm_y(b_ny)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] xs(input logic [15:0] s);
        logic [15:0] t;
        t = s ^ (s << 7);
        t = t ^ (t >> 9);
        return t ^ (t << 8);
    endfunction

    // {x[1:0], y, idx, last_sample, last_frame} for sample n of a 4x2x2 frame
    function automatic logic [63:0] exp_coord(input int n);
        int x, y, idx;
        idx = n % 2;
        x   = (n / 2) % 4;
        y   = n / 8;
        return 64'(x * 16 + y * 8 + idx * 4 + ((idx == 1) ? 2 : 0) + ((n == 15) ? 1 : 0));
    endfunction

    // {norm_x, norm_y}: recip is 2^14 for width 4 and 2^15 for height 2
    function automatic logic [63:0] exp_norm(input int n, input logic [15:0] ox, input logic [15:0] oy);
        longint nx, ny;
        nx = longint'((n / 2) % 4) * 16384 + longint'(ox >> 2);
        ny = longint'(n / 8) * 32768 + longint'(oy >> 1);
        return 64'((nx << 17) | ny);
    endfunction

    task automatic a_frame();
        int n;
        int budget;
        a_ready = 1;
        a_start = 1;
        tick();
        a_start = 0;
        chk("a_busy_after_start", a_busy, 1);
        chk("a_valid_e0", a_valid, 0);
        tick();
        chk("a_valid_e1", a_valid, 0);
        n = 0;
        budget = 0;
        while (n < 16 && budget < 100) begin
            if (a_valid) begin
                chk("a_coord", {a_x, a_y, a_idx, a_ls, a_lf}, exp_coord(n));
                chk("a_norm", {a_nx, a_ny}, exp_norm(n, 16'h8000, 16'h8000));
                if (n == 0) chk("a_first_norm", {a_nx, a_ny}, {17'h02000, 17'h04000});
                if (n == 15) chk("a_last_norm", {a_nx, a_ny}, {17'h0E000, 17'h0C000});
                n++;
            end
            tick();
            budget++;
        end
        chk("a_count", n, 16);
        chk("a_busy_end", a_busy, 0);
        chk("a_valid_end", a_valid, 0);
    endtask

    task automatic c_frame(input int stall_after, output logic [33:0] first_norm);
        int n;
        int budget;
        first_norm = '0;
        c_ready = 1;
        c_start = 1;
        tick();
        c_start = 0;
        n = 0;
        budget = 0;
        while (n < 16 && budget < 100) begin
            if (c_valid) begin
                mx = xs(mx);
                my = xs(my);
                chk("c_coord", {c_x, c_y, c_idx, c_ls, c_lf}, exp_coord(n));
                chk("c_norm", {c_nx, c_ny}, exp_norm(n, mx, my));
                if (n == 0) first_norm = {c_nx, c_ny};
                n++;
                if (n == stall_after) begin
                    tick();
                    budget++;
                    c_ready = 0;
                    for (int k = 0; k < 5; k++) begin
                        tick();
                        chk("c_stall_valid", c_valid, 1);
                        chk("c_stall_coord", {c_x, c_y, c_idx, c_ls, c_lf}, exp_coord(n));
                        chk("c_stall_norm", {c_nx, c_ny}, exp_norm(n, xs(mx), xs(my)));
                    end
                    c_ready = 1;
                    continue;
                end
            end
            tick();
            budget++;
        end
        chk("c_count", n, 16);
        chk("c_busy_end", c_busy, 0);
    endtask

    initial begin
        logic [33:0] f1, f2, f3, f4;
        int n;

        #12;
        chk("a_reset", {a_busy, a_valid, a_x, a_y, a_idx, a_ls, a_lf, a_nx, a_ny}, 0);
        chk("c_reset", {c_busy, c_valid, c_x, c_y, c_idx, c_ls, c_lf, c_nx, c_ny}, 0);
        rst_n = 1;

        a_frame();

        // abort wins over a simultaneous start
        a_start = 1;
        tick();
        a_start = 0;
        repeat (5) tick();
        chk("a_mid_valid", a_valid, 1);
        a_abort = 1;
        a_start = 1;
        tick();
        a_abort = 0;
        a_start = 0;
        chk("a_abort_valid", a_valid, 0);
        chk("a_abort_busy", a_busy, 0);
        tick();
        chk("a_abort_stays_idle", a_busy, 0);
        a_frame();

        // right-edge saturation on an 800-wide frame
        b_ready = 1;
        b_start = 1;
        tick();
        b_start = 0;
        n = 0;
        while (!b_valid && n < 10) begin tick(); n++; end
        chk("b_first_nx", b_nx, 17'h00029);
        n = 0;
        while (!(b_valid && b_x == 10'd798) && n < 2000) begin tick(); n++; end
        chk("b_x798_nx", b_nx, 17'h0FFC5);
        tick();
        chk("b_x799", b_x, 799);
        chk("b_x799_nx", b_nx, 17'h0FFFF);
        n = 0;
        while (b_busy && n < 2000) begin tick(); n++; end
        chk("b_done", b_busy, 0);

        // jitter frames, then one with a 5-cycle stall after the third sample
        c_frame(-1, f1);
        chk("c_first_norm", f1, {17'h0237C, 17'h01344});
        c_frame(-1, f2);
        chk("c_frames_differ", (f1 != f2), 1);
        c_frame(3, f3);

        // reset pulse in the middle of a stall
        c_ready = 1;
        c_start = 1;
        tick();
        c_start = 0;
        repeat (4) tick();
        c_ready = 0;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        chk("c_async_reset", {c_busy, c_valid, c_x, c_y, c_idx, c_ls, c_lf, c_nx, c_ny}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        mx = 16'h1ACE;
        my = 16'hC0DE;
        c_frame(-1, f4);
        chk("c_post_reset_norm", f4, {17'h0237C, 17'h01344});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
